// File: rtl/selector_campo.sv
// Field selector: debounced buttons drive an IDLE/EDIT FSM and a fixed-width increment pulse.
// Optional macro AUTOREPEAT_EN adds hold-to-repeat on btn_arriba.
module selector_campo #(
  parameter int DEB_CYCLES    = 16,
  parameter int PULSE_CYCLES  = 8,
  parameter int HOLD_CYCLES   = 64,
  parameter int REPEAT_CYCLES = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_enter,
  input  logic       btn_der,
  input  logic       btn_izq,
  input  logic       btn_arriba,
  output logic [3:0] cambio,
  output logic       aumenta,
  output logic       editando
);

  localparam int B_ENT = 0;
  localparam int B_DER = 1;
  localparam int B_IZQ = 2;
  localparam int B_ARR = 3;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(PULSE_CYCLES);

  typedef enum logic {IDLE, EDIT} state_t;

  logic [3:0]    w_btn;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_last;
  logic [3:0]    r_clean;
  logic [3:0]    r_cprev;
  logic [3:0]    r_arm;
  logic [DW-1:0] r_cnt [4];
  logic [3:0]    w_ev;

  state_t        r_state;
  logic [3:0]    r_cambio;
  logic [PW-1:0] r_pcnt;
  logic [3:0]    w_next_c;
  logic          w_rep;

  assign w_btn = {btn_arriba, btn_izq, btn_der, btn_enter};

  // r_arm blocks a press until the button has been accepted low once,
  // so a button held through reset never fires on release of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_last  <= '0;
      r_clean <= '0;
      r_cprev <= '0;
      r_arm   <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_s1    <= w_btn;
      r_s2    <= r_s1;
      r_last  <= r_s2;
      r_cprev <= r_clean;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] != r_last[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != DMAX) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else begin
          r_clean[i] <= r_last[i];
          if (!r_last[i]) r_arm[i] <= 1'b1;
        end
      end
    end
  end

  assign w_ev = r_clean & ~r_cprev & r_arm;

  always_comb begin
    w_next_c = r_cambio;
    if (w_ev[B_DER] && !w_ev[B_IZQ])
      w_next_c = (r_cambio >= 4'd9) ? 4'd1 : r_cambio + 4'd1;
    else if (w_ev[B_IZQ] && !w_ev[B_DER])
      w_next_c = (r_cambio <= 4'd1) ? 4'd9 : r_cambio - 4'd1;
  end

`ifdef AUTOREPEAT_EN
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HMAX + 1);

  logic [HW-1:0] r_hcnt;

  assign w_rep = r_clean[B_ARR] && (r_hcnt == HW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != EDIT || !r_clean[B_ARR] || w_ev[B_ENT])
      r_hcnt <= '0;
    else if (w_ev[B_ARR])
      r_hcnt <= HW'(HOLD_CYCLES);
    else if (w_rep)
      r_hcnt <= HW'(REPEAT_CYCLES);
    else if (r_hcnt != '0)
      r_hcnt <= r_hcnt - 1'b1;
  end
`else
  localparam int unused_rep = HOLD_CYCLES + REPEAT_CYCLES;
  assign w_rep = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cambio <= 4'd0;
      r_pcnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_pcnt <= '0;
          if (w_ev[B_ENT]) begin
            r_state  <= EDIT;
            r_cambio <= 4'd1;
          end
        end
        EDIT: begin
          if (w_ev[B_ENT]) begin
            r_state  <= IDLE;
            r_cambio <= 4'd0;
            r_pcnt   <= '0;
          end else if (w_next_c != r_cambio) begin
            r_cambio <= w_next_c;
            r_pcnt   <= '0;
          end else if ((w_ev[B_ARR] || w_rep) && r_pcnt == '0) begin
            r_pcnt <= PMAX;
          end else if (r_pcnt != '0) begin
            r_pcnt <= r_pcnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cambio   = r_cambio;
  assign aumenta  = |r_pcnt;
  assign editando = (r_state == EDIT);

endmodule

// File: tb/tb_selector_campo.sv
// Directed bench for selector_campo with short debounce/pulse/repeat timings.
// Build with or without AUTOREPEAT_EN; the repeat expectations follow the macro.
module tb_selector_campo;

  localparam logic [3:0] ENT = 4'b0001;
  localparam logic [3:0] DER = 4'b0010;
  localparam logic [3:0] IZQ = 4'b0100;
  localparam logic [3:0] ARR = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] cambio;
  logic       aumenta;
  logic       editando;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  selector_campo #(
    .DEB_CYCLES   (4),
    .PULSE_CYCLES (8),
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(10)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .btn_enter (btn[0]),
    .btn_der   (btn[1]),
    .btn_izq   (btn[2]),
    .btn_arriba(btn[3]),
    .cambio    (cambio),
    .aumenta   (aumenta),
    .editando  (editando)
  );

  typedef struct {
    logic [3:0] m;
    logic [3:0] c;
    logic       e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    btn = m;
    tick(10);
    btn = '0;
    tick(10);
  endtask

  task automatic add(input logic [3:0] m, input logic [3:0] c, input logic e);
    vec_t v;
    v.m = m;
    v.c = c;
    v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    int hit, chg, hi, rises, bad, nr;
    logic [3:0] prev_c;
    logic prev_a;
    int offs[8];
    int t0;
    int exp_offs[$];

    add(ENT, 4'd1, 1'b1);
    for (int i = 2; i <= 9; i++) add(DER, 4'(i), 1'b1);
    add(DER, 4'd1, 1'b1);
    add(IZQ, 4'd9, 1'b1);
    add(DER, 4'd1, 1'b1);
    add(DER, 4'd2, 1'b1);
    add(DER, 4'd3, 1'b1);
    add(DER, 4'd4, 1'b1);
    add(ENT | DER, 4'd0, 1'b0);
    add(DER, 4'd0, 1'b0);
    add(IZQ, 4'd0, 1'b0);
    add(ENT, 4'd1, 1'b1);
    add(DER, 4'd2, 1'b1);
    add(DER, 4'd3, 1'b1);
    add(DER, 4'd4, 1'b1);
    add(DER | IZQ, 4'd4, 1'b1);

    btn = '0;
    rst = 1'b1;
    tick(3);
    chk("rst_cambio", cambio, 0);
    chk("rst_editando", editando, 0);
    chk("rst_aumenta", aumenta, 0);
    rst = 1'b0;
    tick(10);

    foreach (tbl[i]) begin
      press(tbl[i].m);
      chk($sformatf("tbl%0d_cambio", i), cambio, tbl[i].c);
      chk($sformatf("tbl%0d_editando", i), editando, tbl[i].e);
      chk($sformatf("tbl%0d_aumenta", i), aumenta, 0);
    end

    // bouncing der: only the final stable rise counts
    for (int i = 0; i < 5; i++) begin
      btn = DER; tick(2);
      btn = '0; tick(2);
    end
    chk("bounce_no_change", cambio, 4);
    btn = DER;
    hit = -1;
    chg = 0;
    prev_c = cambio;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (cambio != prev_c) begin
        chg++;
        if (hit < 0) hit = k;
        prev_c = cambio;
      end
    end
    btn = '0;
    tick(10);
    chk("bounce_changes", chg, 1);
    chk("bounce_cambio", cambio, 5);
    chk("bounce_latency_6to9", int'(hit >= 6 && hit <= 9), 1);

    // single arriba press in EDIT
    btn = ARR;
    hi = 0; rises = 0; prev_a = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (k == 12) btn = '0;
      if (aumenta) hi++;
      if (aumenta && !prev_a) rises++;
      prev_a = aumenta;
    end
    chk("pulse_width", hi, 8);
    chk("pulse_count", rises, 1);

    // arriba in IDLE is ignored
    press(ENT);
    chk("idle_cambio", cambio, 0);
    chk("idle_editando", editando, 0);
    btn = ARR;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (k == 12) btn = '0;
      if (aumenta) hi++;
    end
    chk("idle_no_pulse", hi, 0);
    press(ENT);
    chk("reenter_cambio", cambio, 1);
    chk("reenter_editando", editando, 1);

    // der event 4 cycles into a pulse cuts it short
    btn = ARR;
    tick(4);
    btn = ARR | DER;
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (k == 8) btn = '0;
      if (aumenta) hi++;
    end
    chk("abort_width", hi, 4);
    chk("abort_cambio", cambio, 2);

    // reset during the 4th pulse cycle, buttons held high through release
    for (int i = 0; i < 4; i++) press(DER);
    chk("pre_rst_cambio", cambio, 6);
    btn = ARR;
    for (int k = 0; k < 20 && !aumenta; k++) tick(1);
    chk("rst_pulse_seen", aumenta, 1);
    tick(3);
    rst = 1'b1;
    btn = ARR | DER | ENT;
    tick(1);
    chk("midrst_aumenta", aumenta, 0);
    chk("midrst_cambio", cambio, 0);
    chk("midrst_editando", editando, 0);
    tick(2);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (aumenta || editando || cambio != 4'd0) bad++;
    end
    chk("held_after_rst_quiet", bad, 0);
    btn = '0;
    tick(12);
    press(ENT);
    chk("after_rst_cambio", cambio, 1);
    chk("after_rst_editando", editando, 1);

    // long hold of arriba
    for (int i = 0; i < 8; i++) offs[i] = -1;
    nr = 0; t0 = -1; prev_a = 1'b0;
    btn = ARR;
    for (int k = 0; k < 80; k++) begin
      tick(1);
      if (k == 54) btn = '0;
      if (aumenta && !prev_a) begin
        if (t0 < 0) t0 = k;
        if (nr < 8) offs[nr] = k - t0;
        nr++;
      end
      prev_a = aumenta;
    end
`ifdef AUTOREPEAT_EN
    exp_offs = '{0, 20, 30, 40, 50};
`else
    exp_offs = '{0};
`endif
    chk("hold_pulses", nr, exp_offs.size());
    foreach (exp_offs[i])
      chk($sformatf("hold_off%0d", i), offs[i], exp_offs[i]);
    tick(10);
    chk("hold_end_aumenta", aumenta, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
